// File: rtl/fa4_ctrl_pkg.sv
// fa4_ctrl_pkg: shared constants, state encoding and index-width helper for the serial nibble adder
package fa4_ctrl_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fa_4bit.sv
// fa_4bit: 4-bit ripple adder slice with carry in and carry out
module fa_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/fa4_serial_add_ctrl.sv
// fa4_serial_add_ctrl: adds two 4*NIBBLES-bit operands one nibble per clock through a shared fa_4bit
// Define FA4_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module fa4_serial_add_ctrl
  import fa4_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SLICE_W*NIBBLES-1:0] A_in,
  input  logic [SLICE_W*NIBBLES-1:0] B_in,
  input  logic                       Cin,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NIBBLES-1:0] S_out,
`ifdef FA4_SIGNED_OVF_EN
  output logic                       ovf,
`endif
  output logic                       Co_out
);
  localparam int W  = SLICE_W * NIBBLES;
  localparam int IW = clog2(NIBBLES);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [W-1:0] a_q, b_q;
  logic carry, co, last, accept;
  logic [SLICE_W-1:0] s;
  fa_4bit u_slice (
    .a  (a_q[SLICE_W*int'(idx) +: SLICE_W]),
    .b  (b_q[SLICE_W*int'(idx) +: SLICE_W]),
    .cin(carry),
    .s  (s),
    .co (co)
  );
  always_comb begin
    state_n = (state == ST_RUN) ? (last ? ST_DONE : ST_RUN) : (start ? ST_RUN : ST_IDLE);
    ready   = (state == ST_IDLE) || (state == ST_DONE);
    busy    = state == ST_RUN;
    done    = state == ST_DONE;
    last    = idx == IW'(NIBBLES - 1);
    accept  = ready && start;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      S_out  <= '0;
      Co_out <= 1'b0;
`ifdef FA4_SIGNED_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        a_q    <= A_in;
        b_q    <= B_in;
        carry  <= Cin;
        idx    <= '0;
        S_out  <= '0;
        Co_out <= 1'b0;
`ifdef FA4_SIGNED_OVF_EN
        ovf    <= 1'b0;
`endif
      end else if (busy) begin
        S_out[SLICE_W*int'(idx) +: SLICE_W] <= s;
        carry <= co;
        idx   <= last ? '0 : idx + IW'(1);
        if (last) begin
          Co_out <= co;
`ifdef FA4_SIGNED_OVF_EN
          ovf    <= (a_q[W-1] ~^ b_q[W-1]) & (s[3] ^ a_q[W-1]);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_fa4_serial_add_ctrl.sv
// tb_fa4_serial_add_ctrl: directed vector table plus multi-cycle corner sequences for the serial adder
module tb_fa4_serial_add_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, Cin = 1'b0;
  logic [15:0] A_in = '0, B_in = '0;
  logic ready, busy, done, Co_out;
  logic [15:0] S_out;
`ifdef FA4_SIGNED_OVF_EN
  logic ovf;
`endif
  int checks = 0, failures = 0;
  fa4_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A_in(A_in), .B_in(B_in), .Cin(Cin),
    .ready(ready), .busy(busy), .done(done), .S_out(S_out),
`ifdef FA4_SIGNED_OVF_EN
    .ovf(ovf),
`endif
    .Co_out(Co_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [15:0] a, b;
    logic        c;
    logic [15:0] s;
    logic        co;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int lat, output int busy_n);
    @(negedge clk);
    A_in = a; B_in = b; Cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A_in = ~a; B_in = ~b; Cin = ~c;
    lat = 1; busy_n = 0;
    while (!done && lat < 20) begin
      busy_n += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, bn, seen;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    vecs[2] = '{16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    #1;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s", 32'(S_out), 0);
    chk("rst_co", 32'(Co_out), 0);
`ifdef FA4_SIGNED_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, lat, bn);
      chk($sformatf("v%0d_latency", i), 32'(lat), 5);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bn), 4);
      chk($sformatf("v%0d_ready_in_done", i), 32'(ready), 1);
      chk($sformatf("v%0d_s", i), 32'(S_out), 32'(vecs[i].s));
      chk($sformatf("v%0d_co", i), 32'(Co_out), 32'(vecs[i].co));
`ifdef FA4_SIGNED_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(ovf),
          32'((vecs[i].a[15] == vecs[i].b[15]) && (vecs[i].s[15] != vecs[i].a[15])));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 0);
      chk($sformatf("v%0d_s_held", i), 32'(S_out), 32'(vecs[i].s));
    end
    // start during RUN must not disturb the operation in flight
    @(negedge clk);
    A_in = 16'h00F0; B_in = 16'h0010; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A_in = 16'hFFFF; B_in = 16'hFFFF; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("ign_latency", 32'(lat), 2);
    chk("ign_s", 32'(S_out), 32'h0100);
    chk("ign_co", 32'(Co_out), 0);
    // asynchronous reset in the middle of RUN aborts without done
    @(negedge clk);
    A_in = 16'h1111; B_in = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_s", 32'(S_out), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      seen += int'(done) + int'(busy);
      @(negedge clk);
    end
    chk("abort_no_done", 32'(seen), 0);
    do_op(16'h0005, 16'h0003, 1'b0, lat, bn);
    chk("post_abort_latency", 32'(lat), 5);
    chk("post_abort_s", 32'(S_out), 32'h0008);
    // back-to-back: start held through DONE
    @(negedge clk);
    A_in = 16'h1234; B_in = 16'h1111; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    A_in = 16'h0000; B_in = 16'h0000;
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_first_s", 32'(S_out), 32'h2345);
    A_in = 16'h8000; B_in = 16'h8000;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("b2b_gap", 32'(lat), 5);
    chk("b2b_s", 32'(S_out), 32'h0000);
    chk("b2b_co", 32'(Co_out), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
